// File: rtl/horner_eval.sv
// rtl/horner_eval.sv - Horner polynomial evaluator, FSM plus datapath; overflow flag built only when HORNER_OVF_EN is defined
module horner_eval #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] coef_in,
  input  logic             coef_valid,
  output logic             coef_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [2:0]       state
);

  // Counter must hold DEGREE; a degree-0 polynomial still gets a 1-bit counter.
  localparam int CW = (DEGREE + 1 > 1) ? $clog2(DEGREE + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DEGREE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MUL   = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] coef_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] sum;

`ifdef HORNER_OVF_EN
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]     sum_full;
  logic               ovf_q;

  // Full-width product and sum so that lost high bits can be flagged.
  assign prod_full = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_reg};
  assign sum_full  = {1'b0, acc} + {1'b0, coef_reg};
  assign prod      = prod_full[WIDTH-1:0];
  assign sum       = sum_full[WIDTH-1:0];

  // Sticky overflow: cleared by an accepted start, set by any truncating MUL or carrying ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      case (st)
        S_IDLE:  if (start) ovf_q <= 1'b0;
        S_MUL:   if (|prod_full[2*WIDTH-1:WIDTH]) ovf_q <= 1'b1;
        S_ADD:   if (sum_full[WIDTH]) ovf_q <= 1'b1;
        default: ovf_q <= ovf_q;
      endcase
    end
  end

  assign ovf = ovf_q;
`else
  // Modulo-2^WIDTH arithmetic only; the discarded high bits are never observed.
  assign prod = acc * x_reg;
  assign sum  = acc + coef_reg;
  assign ovf  = 1'b0;
`endif

  // Control FSM and datapath registers; status outputs are registered with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      x_reg    <= '0;
      coef_reg <= '0;
      acc      <= '0;
      result_q <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_reg   <= x_in;
            acc     <= '0;
            cnt     <= CNT_INIT;
            st      <= S_FETCH;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (coef_valid) begin
            coef_reg <= coef_in;
            st       <= S_MUL;
            ready_q  <= 1'b0;
          end
        end
        S_MUL: begin
          acc <= prod;
          st  <= S_ADD;
        end
        S_ADD: begin
          acc <= sum;
          if (cnt == '0) begin
            result_q <= sum;
            st       <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt     <= cnt - CNT_ONE;
            st      <= S_FETCH;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          st     <= S_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          st      <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign coef_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign state      = st;

endmodule

// File: doc/horner_eval.md
# horner_eval

Parametrised Horner-scheme polynomial evaluator combining an FSM control block with its datapath (x, coefficient, accumulator and result registers, multiply and add stages). It replaces the fixed 4-bit hand-derived control/datapath pair. It adds configurable data width and polynomial degree, a streaming coefficient handshake, start/busy/done signalling and optional overflow detection. It sits between the coefficient source and the result consumer in the arithmetic section of the project.

## Interface
- WIDTH, 8: data width of x, coefficients, accumulator and result (≥2).
- DEGREE, 3: polynomial degree N; DEGREE+1 coefficients are consumed per evaluation (≥0).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request an evaluation; sampled only in IDLE.
- x_in  in  WIDTH  evaluation point; captured on the accepted start edge.
- coef_in  in  WIDTH  coefficient data, highest order (c_N) first, c_0 last.
- coef_valid  in  1  coef_in valid.
- coef_ready  out  1  block accepts a coefficient; high only in FETCH.
- result  out  WIDTH  last completed value, held until the next completion or reset.
- busy  out  1  high in FETCH, MUL and ADD.
- done  out  1  single-cycle pulse in DONE.
- ovf  out  1  sticky overflow of the current/last evaluation.
- state  out  3  FSM encoding for debug: IDLE=0, FETCH=1, MUL=2, ADD=3, DONE=4.

## Operation
- Computes acc = (…((0·x + c_N)·x + c_{N-1})·x …)·x + c_0, with all arithmetic modulo 2^WIDTH.
- Internal registers: x_reg, coef_reg, acc, result (all WIDTH), and cnt with max(1, clog2(DEGREE+1)) bits.
- IDLE: when start=1, capture x_in into x_reg, set acc=0, cnt=DEGREE, clear ovf, then go to FETCH. When start=0, stay in IDLE.
- FETCH: coef_ready=1. When coef_valid=1, coef_reg<=coef_in and go to MUL. Otherwise hold; there is no timeout.
- MUL: acc<=low WIDTH bits of acc·x_reg, then go to ADD.
- ADD: acc<=acc+coef_reg (low WIDTH bits).
  - If cnt==0: result<=the same sum, go to DONE.
  - Otherwise: cnt<=cnt−1, go to FETCH.
- DONE: done=1 for one cycle, then unconditionally go to IDLE.
- start is ignored in every state except IDLE, including DONE.
- Unused encodings 5–7 go to IDLE on the next edge.
- Reset, at any time including mid-evaluation:
  - state=IDLE; acc, x_reg, coef_reg, cnt, result=0; ovf=0.
  - Outputs busy=0, done=0, coef_ready=0, state=0.
  - Any partially accepted coefficient sequence is discarded.

## Timing
- Edge 0 accepts start; FETCH is active in cycle 1.
- Each coefficient costs exactly 3 cycles (FETCH, MUL, ADD) when coef_valid is already high. Every cycle coef_valid is low in FETCH adds one cycle.
- Minimum latency: done is high in cycle 3·(DEGREE+1)+1 after the start edge. For DEGREE=3 that is cycle 13; for DEGREE=0, cycle 4.
- result updates on the same edge that enters DONE, so it is valid in the done cycle and afterwards.
- A new start can be accepted in the cycle after DONE, which is the first cycle of IDLE.
- coef_ready depends only on the registered state, never combinationally on coef_valid.

## Configuration
- HORNER_OVF_EN defined:
  - In MUL, ovf is set if the upper WIDTH bits of the full 2·WIDTH product are non-zero.
  - In ADD, ovf is set on carry-out.
  - ovf is sticky until the next accepted start or reset.
- HORNER_OVF_EN undefined: ovf is tied to 0 and no overflow logic is synthesised. The port list is identical in both builds.

## Test plan
- WIDTH=8, DEGREE=3, x=2, coefficients 1,2,3,4 with coef_valid held high -> result=0x1A (26), done pulse in cycle 13 only, busy in cycles 1–12, ovf=0.
- With HORNER_OVF_EN defined: x=16, coefficients 1,0,0,0 -> result=0x00, ovf=1, still 1 in IDLE. The next start with x=1, coefficients 0,0,0,5 -> ovf cleared, result=5.
- Same stimulus as the first scenario, with coef_valid low for 5 cycles before the third coefficient -> state stays 1 and coef_ready stays 1 during the gap, done in cycle 18, result=0x1A.
- start pulsed in MUL and in DONE -> ignored; exactly one done pulse per accepted start, and result is unchanged by the stray pulses.
- rst asserted in cycle 7 of an evaluation -> on the next edge state=0, result=0, busy=0. A fresh evaluation afterwards gives the correct value.
- DEGREE=0, x=0xFF, coefficient 0x42 -> result=0x42, done in cycle 4, ovf=0.
